// File: rtl/pid_trap_ctrl.sv
// pid_trap_ctrl: shortest-path PID steer controller with an
// accel/cruise/decel profile, anti-windup and startup-stall guard.
module pid_trap_ctrl #(
  parameter int ANGLE_W        = 12,
  parameter int RATIO_W        = 8,
  parameter int STEPS          = 8,
  parameter int DECEL_DIST     = 50,
  parameter int DONE_TOL       = 10,
  parameter int STALL_SAMPLES  = 16,
  parameter int STALL_MIN_MOVE = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ANGLE_W-1:0]   target_angle,
  input  logic [ANGLE_W-1:0]   current_angle,
  input  logic                 sample_valid,
  input  logic                 angle_update,
  input  logic                 abort_angle,
  input  logic                 pwm_enable,
  input  logic [8*STEPS-1:0]   profile,
  input  logic [7:0]           kp,
  input  logic [3:0]           ki,
  input  logic [3:0]           kd,
  input  logic                 enable_stall_chk,
  input  logic                 pwm_done,
  output logic [RATIO_W-1:0]   pwm_ratio,
  output logic                 pwm_update,
  output logic                 pwm_direction,
  output logic                 angle_done,
  output logic                 startup_fail,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int AW  = ANGLE_W + 4;
  localparam int PW  = ANGLE_W + 8;
  localparam int IW  = AW + 4;
  localparam int DW  = ANGLE_W + 6;
  localparam int SMW = ANGLE_W + 6;
  localparam int XW  = RATIO_W + 8;
  localparam int STW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CW  = $clog2(STALL_SAMPLES + 1);

  localparam logic [ANGLE_W-1:0] HALF =
    {1'b1, {(ANGLE_W-1){1'b0}}};
  localparam logic [ANGLE_W-1:0] DEC_D  = ANGLE_W'(DECEL_DIST);
  localparam logic [ANGLE_W-1:0] DONE_T = ANGLE_W'(DONE_TOL);
  localparam logic [ANGLE_W-1:0] MIN_MV = ANGLE_W'(STALL_MIN_MOVE);
  localparam logic [STW-1:0] STEP_MAX   = STW'(STEPS - 1);
  localparam logic [CW-1:0]  CNT_HIT    = CW'(STALL_SAMPLES - 1);
  localparam logic [CW-1:0]  CNT_SAT    = CW'(STALL_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state;

  logic               sv_q;
  logic               s1_valid;
  logic               s1_dir;
  logic [ANGLE_W-1:0] s1_err;
  logic [ANGLE_W-1:0] s1_move;
  logic [RATIO_W-1:0] s1_raw;
  logic [ANGLE_W-1:0] last_err;
  logic [ANGLE_W-1:0] start_angle;
  logic [AW-1:0]      acc;
  logic [STW-1:0]     step;
  logic [CW-1:0]      smp_cnt;

  logic smp, kill, active;

  assign smp    = sample_valid & ~sv_q;
  assign kill   = abort_angle | ~pwm_enable;
  assign active = (state == S_ACCEL) |
                  (state == S_CRUISE) |
                  (state == S_DECEL);

  // stage 1: shortest-path error and PID terms
  logic [ANGLE_W-1:0] diff, err_c, md, move_c;
  logic               dir_c;

  assign diff   = target_angle - current_angle;
  assign dir_c  = (diff <= HALF);
  assign err_c  = dir_c ? diff : ('0 - diff);
  assign md     = current_angle - start_angle;
  assign move_c = (md <= HALF) ? md : ('0 - md);

  logic [AW:0]   acc_sum;
  logic [AW-1:0] acc_nx;

  assign acc_sum = {1'b0, acc} +
                   {{(AW+1-ANGLE_W){1'b0}}, err_c};
  assign acc_nx  = acc_sum[AW] ? '1 : acc_sum[AW-1:0];

  logic        [PW-1:0]      p_prod;
  logic        [IW-1:0]      i_prod;
  logic signed [ANGLE_W+1:0] d_diff;
  logic signed [DW-1:0]      d_prod;
  logic signed [SMW-1:0]     pid_sum;
  logic        [RATIO_W-1:0] raw_c;

  assign p_prod = {{ANGLE_W{1'b0}}, kp} * {8'd0, err_c};
  assign i_prod = {{AW{1'b0}}, ki} * {4'd0, acc_nx};
  assign d_diff = $signed({2'b00, err_c}) -
                  $signed({2'b00, last_err});
  assign d_prod = $signed({{4{d_diff[ANGLE_W+1]}}, d_diff}) *
                  $signed({{(DW-4){1'b0}}, kd});

  assign pid_sum =
    $signed({2'b00, p_prod[PW-1:4]}) +
    $signed({6'd0, i_prod[IW-1:8]}) +
    $signed({{4{d_prod[DW-1]}}, d_prod[DW-1:4]});

  assign raw_c = pid_sum[SMW-1]           ? '0 :
                 (|pid_sum[SMW-2:RATIO_W]) ? '1 :
                 pid_sum[RATIO_W-1:0];

  // stage 2: profile scaling and stall test
  logic [7:0]         coeff;
  logic [XW-1:0]      s_prod;
  logic [RATIO_W+3:0] scaled;
  logic [RATIO_W-1:0] cmd_scaled;
  logic               stall_hit;

  assign coeff      = profile[8*int'(step) +: 8];
  assign s_prod     = {8'd0, s1_raw} * {{RATIO_W{1'b0}}, coeff};
  assign scaled     = s_prod[XW-1:4];
  assign cmd_scaled = (|scaled[RATIO_W+3:RATIO_W]) ?
                      '1 : scaled[RATIO_W-1:0];
  assign stall_hit  = (state == S_ACCEL) & enable_stall_chk &
                      (smp_cnt == CNT_HIT) & (s1_move < MIN_MV);

  logic unused_bits;
  assign unused_bits = ^{p_prod[3:0], i_prod[7:0],
                         d_prod[3:0], s_prod[3:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sv_q          <= 1'b0;
      s1_valid      <= 1'b0;
      s1_dir        <= 1'b0;
      s1_err        <= '0;
      s1_move       <= '0;
      s1_raw        <= '0;
      last_err      <= '0;
      start_angle   <= '0;
      acc           <= '0;
      step          <= '0;
      smp_cnt       <= '0;
      pwm_ratio     <= '0;
      pwm_update    <= 1'b0;
      pwm_direction <= 1'b0;
      angle_done    <= 1'b0;
      startup_fail  <= 1'b0;
    end else begin
      sv_q     <= sample_valid;
      s1_valid <= 1'b0;
      if (pwm_update && pwm_done)
        pwm_update <= 1'b0;

      if (kill) begin
        if (state != S_IDLE) begin
          state      <= S_IDLE;
          pwm_ratio  <= '0;
          pwm_update <= 1'b1;
          angle_done <= 1'b0;
        end
      end else if (angle_update) begin
        state        <= S_ACCEL;
        angle_done   <= 1'b0;
        startup_fail <= 1'b0;
        acc          <= '0;
        last_err     <= '0;
        step         <= '0;
        smp_cnt      <= '0;
        start_angle  <= current_angle;
      end else begin
        if (state == S_DONE)
          state <= S_IDLE;

        if (smp && active) begin
          s1_valid <= 1'b1;
          s1_err   <= err_c;
          s1_dir   <= dir_c;
          s1_raw   <= raw_c;
          s1_move  <= move_c;
          acc      <= acc_nx;
          last_err <= err_c;
        end

        if (s1_valid && active) begin
          if (smp_cnt != CNT_SAT)
            smp_cnt <= smp_cnt + CW'(1);
          pwm_update    <= 1'b1;
          pwm_direction <= s1_dir;
          if (stall_hit) begin
            startup_fail <= 1'b1;
            pwm_ratio    <= '0;
            state        <= S_IDLE;
          end else if (s1_err <= DONE_T) begin
            pwm_ratio  <= '0;
            angle_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            unique case (state)
              S_ACCEL: begin
                pwm_ratio <= cmd_scaled;
                if (s1_err < DEC_D)
                  state <= S_DECEL;
                else if (step == STEP_MAX)
                  state <= S_CRUISE;
                else
                  step <= step + STW'(1);
              end
              S_CRUISE: begin
                pwm_ratio <= s1_raw;
                if (s1_err < DEC_D) begin
                  state <= S_DECEL;
                  step  <= STEP_MAX;
                end
              end
              S_DECEL: begin
                pwm_ratio <= cmd_scaled;
                if (step != '0)
                  step <= step - STW'(1);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_pid_trap_ctrl.sv
// Directed bench for pid_trap_ctrl: profile, wrap-around,
// stall, abort, anti-windup and async reset scenarios.
module tb_pid_trap_ctrl;

  logic        clock;
  logic        reset_n;
  logic [11:0] target_angle;
  logic [11:0] current_angle;
  logic        sample_valid;
  logic        angle_update;
  logic        abort_angle;
  logic        pwm_enable;
  logic [63:0] profile;
  logic [7:0]  kp;
  logic [3:0]  ki;
  logic [3:0]  kd;
  logic        enable_stall_chk;
  logic        pwm_done;
  logic [7:0]  pwm_ratio;
  logic        pwm_update;
  logic        pwm_direction;
  logic        angle_done;
  logic        startup_fail;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  pid_trap_ctrl #(.STALL_SAMPLES(8)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .target_angle(target_angle),
    .current_angle(current_angle),
    .sample_valid(sample_valid),
    .angle_update(angle_update),
    .abort_angle(abort_angle),
    .pwm_enable(pwm_enable),
    .profile(profile),
    .kp(kp),
    .ki(ki),
    .kd(kd),
    .enable_stall_chk(enable_stall_chk),
    .pwm_done(pwm_done),
    .pwm_ratio(pwm_ratio),
    .pwm_update(pwm_update),
    .pwm_direction(pwm_direction),
    .angle_done(angle_done),
    .startup_fail(startup_fail),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [11:0] tgt,
                       input logic [11:0] cur);
    target_angle  = tgt;
    current_angle = cur;
    angle_update  = 1'b1;
    tick();
    angle_update  = 1'b0;
  endtask

  task automatic sample(input logic [11:0] cur);
    current_angle = cur;
    sample_valid  = 1'b1;
    tick();
    sample_valid  = 1'b0;
    tick();
  endtask

  task automatic ack();
    pwm_done = 1'b1;
    tick();
    pwm_done = 1'b0;
  endtask

  task automatic go_idle();
    abort_angle = 1'b1;
    tick();
    abort_angle = 1'b0;
    ack();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (pwm_ratio !== 8'd0) begin
      errors++;
      $display("FAIL reset_ratio: got %0d want 0", pwm_ratio);
    end
    checks++;
    if ({pwm_update, pwm_direction, angle_done,
         startup_fail, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {pwm_update, pwm_direction, angle_done,
                startup_fail, busy});
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    kp = 8'h10; ki = 4'h0; kd = 4'h0;
    profile = {8{8'h10}};
    start(12'd1000, 12'd0);
    checks++;
    if (state_dbg !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accel: got state %0d busy %b want 1 1",
               state_dbg, busy);
    end
    sample(12'd0);
    checks++;
    if (pwm_ratio !== 8'd255 || pwm_direction !== 1'b1) begin
      errors++;
      $display("FAIL basic_ratio: got %0d dir %b want 255 dir 1",
               pwm_ratio, pwm_direction);
    end
    tick();
    tick();
    checks++;
    if (pwm_update !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: got update %b want 1", pwm_update);
    end
    ack();
    checks++;
    if (pwm_update !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop: got update %b want 0", pwm_update);
    end
    go_idle();
  endtask

  task automatic test_wrap();
    logic [11:0] tg [3] = '{12'd10, 12'd4090, 12'd2048};
    logic [11:0] cu [3] = '{12'd4090, 12'd10, 12'd0};
    logic [7:0]  er [3] = '{8'd16, 8'd16, 8'd255};
    logic        dr [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start(tg[i], cu[i]);
      sample(cu[i]);
      checks++;
      if (pwm_ratio !== er[i] || pwm_direction !== dr[i]) begin
        errors++;
        $display("FAIL wrap_%0d: got %0d dir %b want %0d dir %b",
                 i, pwm_ratio, pwm_direction, er[i], dr[i]);
      end
      ack();
    end
    go_idle();
  endtask

  task automatic test_profile();
    logic [7:0] exp_r [8] = '{8'd63, 8'd127, 8'd255, 8'd255,
                              8'd255, 8'd255, 8'd255, 8'd127};
    logic [2:0] exp_s;
    profile = {8'h08, 8'h10, 8'h10, 8'h10,
               8'h10, 8'h10, 8'h08, 8'h04};
    start(12'd1000, 12'd0);
    for (int i = 0; i < 8; i++) begin
      sample(12'd0);
      exp_s = (i == 7) ? 3'd2 : 3'd1;
      checks++;
      if (pwm_ratio !== exp_r[i] || state_dbg !== exp_s) begin
        errors++;
        $display("FAIL accel_%0d: got %0d st %0d want %0d st %0d",
                 i, pwm_ratio, state_dbg, exp_r[i], exp_s);
      end
      ack();
    end
    sample(12'd800);
    checks++;
    if (pwm_ratio !== 8'd200 || state_dbg !== 3'd2) begin
      errors++;
      $display("FAIL cruise: got %0d st %0d want 200 st 2",
               pwm_ratio, state_dbg);
    end
    ack();
    sample(12'd960);
    checks++;
    if (pwm_ratio !== 8'd40 || state_dbg !== 3'd3) begin
      errors++;
      $display("FAIL to_decel: got %0d st %0d want 40 st 3",
               pwm_ratio, state_dbg);
    end
    ack();
    sample(12'd970);
    checks++;
    if (pwm_ratio !== 8'd15 || state_dbg !== 3'd3) begin
      errors++;
      $display("FAIL decel: got %0d st %0d want 15 st 3",
               pwm_ratio, state_dbg);
    end
    ack();
    sample(12'd992);
    checks++;
    if (pwm_ratio !== 8'd0 || state_dbg !== 3'd4 ||
        angle_done !== 1'b1 || pwm_update !== 1'b1) begin
      errors++;
      $display("FAIL done: got %0d st %0d dn %b up %b want 0 4 1 1",
               pwm_ratio, state_dbg, angle_done, pwm_update);
    end
    ack();
    tick();
    checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 ||
        angle_done !== 1'b1) begin
      errors++;
      $display("FAIL done_idle: got busy %b st %0d dn %b want 0 0 1",
               busy, state_dbg, angle_done);
    end
  endtask

  task automatic test_zero_err();
    profile = {8{8'h10}};
    start(12'd500, 12'd500);
    checks++;
    if (angle_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear: got done %b want 0", angle_done);
    end
    sample(12'd500);
    checks++;
    if (state_dbg !== 3'd4 || angle_done !== 1'b1 ||
        pwm_ratio !== 8'd0) begin
      errors++;
      $display("FAIL zero_done: got st %0d dn %b r %0d want 4 1 0",
               state_dbg, angle_done, pwm_ratio);
    end
    ack();
  endtask

  task automatic test_stall();
    enable_stall_chk = 1'b1;
    start(12'd1000, 12'd100);
    for (int i = 0; i < 7; i++) begin
      sample(12'd100);
      ack();
    end
    checks++;
    if (startup_fail !== 1'b0 || state_dbg !== 3'd1 ||
        pwm_ratio !== 8'd255) begin
      errors++;
      $display("FAIL stall_early: got f %b st %0d r %0d want 0 1 255",
               startup_fail, state_dbg, pwm_ratio);
    end
    sample(12'd100);
    checks++;
    if (startup_fail !== 1'b1 || state_dbg !== 3'd0 ||
        pwm_ratio !== 8'd0 || pwm_update !== 1'b1 ||
        angle_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_hit: got f %b st %0d r %0d up %b dn %b",
               startup_fail, state_dbg, pwm_ratio, pwm_update,
               angle_done);
    end
    ack();
    start(12'd1000, 12'd100);
    checks++;
    if (startup_fail !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: got %b want 0", startup_fail);
    end
    go_idle();
    enable_stall_chk = 1'b0;
  endtask

  task automatic test_abort();
    start(12'd1000, 12'd0);
    for (int i = 0; i < 8; i++) begin
      sample(12'd0);
      ack();
    end
    current_angle = 12'd0;
    sample_valid  = 1'b1;
    abort_angle   = 1'b1;
    tick();
    sample_valid  = 1'b0;
    abort_angle   = 1'b0;
    checks++;
    if (state_dbg !== 3'd0 || pwm_ratio !== 8'd0 ||
        pwm_update !== 1'b1 || angle_done !== 1'b0) begin
      errors++;
      $display("FAIL abort: got st %0d r %0d up %b dn %b",
               state_dbg, pwm_ratio, pwm_update, angle_done);
    end
    tick();
    tick();
    checks++;
    if (pwm_ratio !== 8'd0) begin
      errors++;
      $display("FAIL abort_drop: got %0d want 0", pwm_ratio);
    end
    ack();
    tick();
    tick();
    checks++;
    if (pwm_update !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got update %b want 0", pwm_update);
    end
    start(12'd1000, 12'd0);
    sample(12'd0);
    ack();
    current_angle = 12'd0;
    sample_valid  = 1'b1;
    pwm_enable    = 1'b0;
    tick();
    sample_valid  = 1'b0;
    pwm_enable    = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 3'd0 || pwm_ratio !== 8'd0) begin
      errors++;
      $display("FAIL disable: got st %0d r %0d want 0 0",
               state_dbg, pwm_ratio);
    end
    ack();
  endtask

  task automatic test_windup();
    kp = 8'h00; ki = 4'h8; kd = 4'h0;
    start(12'd1000, 12'd0);
    sample(12'd0);
    checks++;
    if (pwm_ratio !== 8'd31) begin
      errors++;
      $display("FAIL windup_i1: got %0d want 31", pwm_ratio);
    end
    ack();
    sample(12'd0);
    checks++;
    if (pwm_ratio !== 8'd62) begin
      errors++;
      $display("FAIL windup_i2: got %0d want 62", pwm_ratio);
    end
    ack();
    for (int i = 0; i < 68; i++) begin
      sample(12'd0);
      ack();
    end
    checks++;
    if (dut.acc !== 16'hFFFF || pwm_ratio !== 8'd255) begin
      errors++;
      $display("FAIL windup_sat: got acc %0d r %0d want 65535 255",
               dut.acc, pwm_ratio);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    kp = 8'h10; ki = 4'h0; kd = 4'h0;
    start(12'd1000, 12'd0);
    sample(12'd0);
    ack();
    sample(12'd960);
    checks++;
    if (state_dbg !== 3'd3 || pwm_ratio !== 8'd40) begin
      errors++;
      $display("FAIL pre_reset: got st %0d r %0d want 3 40",
               state_dbg, pwm_ratio);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pwm_ratio, pwm_update, pwm_direction,
         busy, state_dbg} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: got r %0d up %b dir %b st %0d",
               pwm_ratio, pwm_update, pwm_direction, state_dbg);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n          = 1'b0;
    target_angle     = '0;
    current_angle    = '0;
    sample_valid     = 1'b0;
    angle_update     = 1'b0;
    abort_angle      = 1'b0;
    pwm_enable       = 1'b1;
    profile          = '0;
    kp               = '0;
    ki               = '0;
    kd               = '0;
    enable_stall_chk = 1'b0;
    pwm_done         = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_profile();
    test_zero_err();
    test_stall();
    test_abort();
    test_windup();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
